// File: rtl/tl_cntr_param.sv
// Parametrised round-robin traffic-light controller: straight and optional left-turn
// phases per approach, min/max green, multi-cycle yellow and a night flashing mode.
module tl_cntr_param #(
  parameter int N_DIR   = 2,
  parameter int LEFT_EN = 1,
  parameter int YEL_CYC = 3,
  parameter int MIN_GRN = 2,
  parameter int MAX_GRN = 15,
  localparam int DW = (N_DIR > 1) ? $clog2(N_DIR) : 1,
  localparam int TW = $clog2(MAX_GRN + YEL_CYC + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_DIR-1:0] t_str,
  input  logic [N_DIR-1:0] t_left,
  input  logic             night,
  output logic [N_DIR-1:0] grn,
  output logic [N_DIR-1:0] yel,
  output logic [N_DIR-1:0] lgrn,
  output logic [N_DIR-1:0] lyel,
  output logic [DW-1:0]    dir,
  output logic [2:0]       stage
);

  localparam logic [2:0] ST_SG = 3'd0;
  localparam logic [2:0] ST_SY = 3'd1;
  localparam logic [2:0] ST_LG = 3'd2;
  localparam logic [2:0] ST_LY = 3'd3;
  localparam logic [2:0] ST_FL = 3'd4;

  localparam logic [TW-1:0] T_MIN  = TW'(MIN_GRN - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(MAX_GRN - 1);
  localparam logic [TW-1:0] T_YEL  = TW'(YEL_CYC - 1);
  localparam logic [DW-1:0] D_LAST = DW'(N_DIR - 1);

  logic [2:0]    stage_q, stage_n;
  logic [DW-1:0] dir_q, dir_n, dir_inc;
  logic [TW-1:0] timer_q, timer_n;
  logic          blink_q, blink_n;
  logic          sense, grn_exit, yel_exit, left_req;

  // Round-robin successor; never steps into unused encodings when N_DIR is not a power of 2
  assign dir_inc  = (dir_q == D_LAST) ? '0 : dir_q + 1'b1;
  assign sense    = (stage_q == ST_LG) ? t_left[dir_q] : t_str[dir_q];
  assign grn_exit = (timer_q == T_MAX) || ((timer_q >= T_MIN) && (!sense || night));
  assign yel_exit = (timer_q == T_YEL);
  assign left_req = (LEFT_EN != 0) && t_left[dir_q];

  always_comb begin
    stage_n = stage_q;
    dir_n   = dir_q;
    timer_n = timer_q + 1'b1;
    blink_n = blink_q;
    case (stage_q)
      ST_SG, ST_LG: begin
        if (grn_exit) begin
          stage_n = (stage_q == ST_SG) ? ST_SY : ST_LY;
          timer_n = '0;
        end
      end
      ST_SY, ST_LY: begin
        if (yel_exit) begin
          timer_n = '0;
          if (night) begin
            stage_n = ST_FL;
            dir_n   = '0;
            blink_n = 1'b1;
          end else if (stage_q == ST_SY && left_req) begin
            stage_n = ST_LG;
          end else begin
            stage_n = ST_SG;
            dir_n   = dir_inc;
          end
        end
      end
      ST_FL: begin
        if (!night) begin
          stage_n = ST_SG;
          dir_n   = '0;
          timer_n = '0;
          blink_n = 1'b0;
        end else if (yel_exit) begin
          timer_n = '0;
          blink_n = ~blink_q;
        end
      end
      default: begin
        stage_n = ST_SG;
        dir_n   = '0;
        timer_n = '0;
        blink_n = 1'b0;
      end
    endcase
  end

  // State register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= ST_SG;
      dir_q   <= '0;
      timer_q <= '0;
      blink_q <= 1'b0;
    end else begin
      stage_q <= stage_n;
      dir_q   <= dir_n;
      timer_q <= timer_n;
      blink_q <= blink_n;
    end
  end

  // Moore lamp decode from registered state only
  always_comb begin
    grn  = '0;
    yel  = '0;
    lgrn = '0;
    lyel = '0;
    case (stage_q)
      ST_SG:   grn[dir_q]  = 1'b1;
      ST_SY:   yel[dir_q]  = 1'b1;
      ST_LG:   lgrn[dir_q] = 1'b1;
      ST_LY:   lyel[dir_q] = 1'b1;
      ST_FL:   yel = {N_DIR{blink_q}};
      default: ;
    endcase
  end

  assign stage = stage_q;
  assign dir   = dir_q;

endmodule

// File: tb/tb_tl_cntr_param.sv
// Bench for tl_cntr_param (N_DIR=2, LEFT_EN=1, YEL_CYC=3, MIN_GRN=2, MAX_GRN=6):
// scenario tasks plus a randomized run, all against a phase-level reference model.
module tb_tl_cntr_param;

  localparam int N_DIR = 2;
  localparam int LEFT_EN = 1;
  localparam int YEL_CYC = 3;
  localparam int MIN_GRN = 2;
  localparam int MAX_GRN = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] t_str, t_left;
  logic       night;
  logic [1:0] grn, yel, lgrn, lyel;
  logic [0:0] dir;
  logic [2:0] stage;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: current phase (0=SG,1=SY,2=LG,3=LY,4=FLASH), approach, cycles spent, blink
  int m_stage, m_dir, m_age;
  bit m_blink;

  tl_cntr_param #(
    .N_DIR(N_DIR), .LEFT_EN(LEFT_EN), .YEL_CYC(YEL_CYC),
    .MIN_GRN(MIN_GRN), .MAX_GRN(MAX_GRN)
  ) dut (
    .clk(clk), .reset(reset), .t_str(t_str), .t_left(t_left), .night(night),
    .grn(grn), .yel(yel), .lgrn(lgrn), .lyel(lyel), .dir(dir), .stage(stage)
  );

  always #5 clk = ~clk;

  task automatic enter(input int s, input int d);
    m_stage = s;
    m_dir   = (s == 4) ? 0 : d;
    m_age   = 0;
    m_blink = (s == 4);
  endtask

  task automatic model_reset();
    enter(0, 0);
  endtask

  task automatic model_step(input logic [1:0] ts, input logic [1:0] tl, input logic nt);
    bit green_over, yellow_over;
    int nxt;
    nxt = (m_dir + 1) % N_DIR;
    yellow_over = (m_age + 1 >= YEL_CYC);
    case (m_stage)
      0, 2: begin
        green_over = (m_age + 1 >= MAX_GRN) ||
                     (m_age + 1 >= MIN_GRN && (nt || !((m_stage == 0) ? ts[m_dir] : tl[m_dir])));
        if (green_over) enter(m_stage + 1, m_dir);
        else m_age++;
      end
      1: begin
        if (!yellow_over) m_age++;
        else if (nt) enter(4, 0);
        else if (LEFT_EN != 0 && tl[m_dir]) enter(2, m_dir);
        else enter(0, nxt);
      end
      3: begin
        if (!yellow_over) m_age++;
        else if (nt) enter(4, 0);
        else enter(0, nxt);
      end
      default: begin
        if (!nt) enter(0, 0);
        else if (yellow_over) begin
          m_blink = !m_blink;
          m_age = 0;
        end else m_age++;
      end
    endcase
  endtask

  function automatic logic [11:0] exp_out();
    logic [1:0] lamp, y;
    lamp = 2'(1 << m_dir);
    y = (m_stage == 4) ? {2{m_blink}} : ((m_stage == 1) ? lamp : 2'b00);
    return {3'(m_stage), 1'(m_dir), (m_stage == 0) ? lamp : 2'b00, y,
            (m_stage == 2) ? lamp : 2'b00, (m_stage == 3) ? lamp : 2'b00};
  endfunction

  function automatic logic [11:0] obs();
    return {stage, dir, grn, yel, lgrn, lyel};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(t_str, t_left, night);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; t_str = '0; t_left = '0; night = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (obs() !== 12'b000_0_01_00_00_00) begin
      n_fail++;
      $display("FAIL reset_pre_edge got=%h exp=%h", obs(), 12'b000_0_01_00_00_00);
    end
    for (int i = 0; i < 3; i++) begin
      t_str = 2'(i + 1); night = i[0];
      @(posedge clk); #1;
      n_tests++;
      if (obs() !== 12'b000_0_01_00_00_00) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs(), 12'b000_0_01_00_00_00);
      end
    end
    @(negedge clk);
    t_str = '0; night = 1'b0;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_idle();
    logic [2:0] st_tbl [10];
    logic       dr_tbl [10];
    st_tbl = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
    dr_tbl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    t_str = '0; t_left = '0; night = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) tick();
      n_tests++;
      if ({stage, dir, grn, lgrn} !== {st_tbl[i % 10], dr_tbl[i % 10],
          (st_tbl[i % 10] == 3'd0) ? (dr_tbl[i % 10] ? 2'b10 : 2'b01) : 2'b00, 2'b00}) begin
        n_fail++;
        $display("FAIL idle_seq cyc=%0d got_stage=%0d got_dir=%0d got_grn=%b exp_stage=%0d exp_dir=%0d",
                 i, stage, dir, grn, st_tbl[i % 10], dr_tbl[i % 10]);
      end
    end
  endtask

  task automatic test_timeout();
    int cnt;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      t_str = 2'b01; t_left = '0; night = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
        if (grn == 2'b01) cnt++;
        else break;
        if (pass == 1 && m_stage == 0 && m_dir == 0 && m_age == 3) t_str = 2'b00;
        tick();
        n_tests++;
        if (obs() !== exp_out()) begin
          n_fail++;
          $display("FAIL timeout_model pass=%0d cyc=%0d got=%h exp=%h", pass, i, obs(), exp_out());
        end
      end
      n_tests++;
      if (cnt !== ((pass == 0) ? 6 : 4)) begin
        n_fail++;
        $display("FAIL timeout_len pass=%0d got=%0d exp=%0d", pass, cnt, (pass == 0) ? 6 : 4);
      end
    end
  endtask

  task automatic test_left();
    int lg_cnt, ly_cnt, lg0_cnt;
    do_reset();
    t_str = '0; t_left = 2'b01; night = 1'b0;
    lg_cnt = 0; ly_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (m_stage == 2 && m_age == 0) t_left = 2'b00;
      tick();
      if (lgrn == 2'b01) lg_cnt++;
      if (lyel == 2'b01) ly_cnt++;
      n_tests++;
      if (obs() !== exp_out()) begin
        n_fail++;
        $display("FAIL left_model cyc=%0d got=%h exp=%h", i, obs(), exp_out());
      end
    end
    n_tests++;
    if ({lg_cnt, ly_cnt} !== {32'd2, 32'd3}) begin
      n_fail++;
      $display("FAIL left_len got_lg=%0d got_ly=%0d exp_lg=2 exp_ly=3", lg_cnt, ly_cnt);
    end
    // Late demand: raised only once SY0 has finished, must not open LG0 this round
    do_reset();
    t_left = 2'b00;
    lg0_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      if (m_stage == 0 && m_dir == 1) t_left = 2'b01;
      tick();
      if (lgrn[0]) lg0_cnt++;
      n_tests++;
      if (obs() !== exp_out()) begin
        n_fail++;
        $display("FAIL left_skip_model cyc=%0d got=%h exp=%h", i, obs(), exp_out());
      end
    end
    n_tests++;
    if (lg0_cnt !== 0) begin
      n_fail++;
      $display("FAIL left_skip got_lg0_cycles=%0d exp=0", lg0_cnt);
    end
  endtask

  task automatic test_night();
    bit reached;
    do_reset();
    t_str = 2'b10; t_left = '0; night = 1'b0;
    reached = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      if (m_stage == 0 && m_dir == 1 && m_age == 4) night = 1'b1;
      tick();
      n_tests++;
      if (obs() !== exp_out()) begin
        n_fail++;
        $display("FAIL night_model cyc=%0d got=%h exp=%h", i, obs(), exp_out());
      end
      if (m_stage == 4) reached = 1;
    end
    n_tests++;
    if (!reached || yel !== 2'b11 || stage !== 3'd4) begin
      n_fail++;
      $display("FAIL night_flash_entry got_stage=%0d got_yel=%b exp_stage=4 exp_yel=11", stage, yel);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (yel !== (((i + 1) % 6 < 3) ? 2'b11 : 2'b00) || obs() !== exp_out()) begin
        n_fail++;
        $display("FAIL night_blink cyc=%0d got=%h exp=%h", i, obs(), exp_out());
      end
    end
    night = 1'b0;
    tick();
    n_tests++;
    if ({stage, dir, grn, yel} !== {3'd0, 1'b0, 2'b01, 2'b00}) begin
      n_fail++;
      $display("FAIL night_exit got_stage=%0d got_dir=%0d got_grn=%b exp_stage=0 exp_dir=0 exp_grn=01",
               stage, dir, grn);
    end
  endtask

  task automatic test_async_reset();
    bit reached;
    do_reset();
    t_str = '0; t_left = 2'b01; night = 1'b0;
    reached = 0;
    for (int i = 0; i < 30 && !reached; i++) begin
      if (m_stage == 2) t_left = 2'b00;
      tick();
      if (m_stage == 3 && m_age == 1) reached = 1;
    end
    n_tests++;
    if (!reached || lyel !== 2'b01) begin
      n_fail++;
      $display("FAIL async_setup got_lyel=%b exp_lyel=01", lyel);
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if (obs() !== 12'b000_0_01_00_00_00) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=%h", obs(), 12'b000_0_01_00_00_00);
    end
    @(negedge clk);
    reset = 1'b0;
    t_left = '0;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      n_tests++;
      if (obs() !== exp_out() || stage !== ((i % 5 < 2) ? 3'd0 : 3'd1)) begin
        n_fail++;
        $display("FAIL async_restart cyc=%0d got=%h exp=%h", i, obs(), exp_out());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      t_str  = 2'($urandom);
      t_left = 2'($urandom);
      if ($urandom_range(0, 19) == 0) night = ~night;
      tick();
      n_tests++;
      if (obs() !== exp_out()) begin
        n_fail++;
        $display("FAIL random cyc=%0d in_s=%b in_l=%b night=%b got=%h exp=%h",
                 i, t_str, t_left, night, obs(), exp_out());
      end
    end
    night = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_timeout();
    test_left();
    test_night();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_cntr_param.md
Name: tl_cntr_param

Overview:
- Parametrised successor to the fixed 2-approach traffic-light controller with left-turn phases.
- Drives N_DIR approaches. Each approach has a straight phase and an optional left-turn phase, served in round-robin order.
- Adds min/max green timing, multi-cycle yellow, demand-based left-phase skipping, and a night flashing mode.
- Sits between the sensor inputs and the lamp drivers; it is a Moore machine and all outputs decode from the registered state.

Parameters:
N_DIR, 2, number of approaches (2..4)
LEFT_EN, 1, 1 = left-turn phases exist; 0 = left phases are never entered
YEL_CYC, 3, yellow duration in cycles; also the flash half-period (>=1)
MIN_GRN, 2, minimum green cycles (>=1)
MAX_GRN, 15, maximum green cycles (>=MIN_GRN)
(derived) DW = (N_DIR>1) ? $clog2(N_DIR) : 1
(derived) TW = $clog2(MAX_GRN+YEL_CYC+1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
t_str  in  N_DIR  straight-traffic sensor per approach
t_left  in  N_DIR  left-turn demand per approach
night  in  1  request for flashing mode
grn  out  N_DIR  straight green per approach
yel  out  N_DIR  straight yellow per approach (also the flash lamp)
lgrn  out  N_DIR  left-arrow green per approach
lyel  out  N_DIR  left-arrow yellow per approach
dir  out  DW  approach currently served
stage  out  3  0=SG, 1=SY, 2=LG, 3=LY, 4=FLASH

Behaviour:
- State is {stage, dir, timer[TW-1:0], blink}. timer = 0 on the first cycle of every phase and increments by 1 each cycle in the phase.
- Reset (async, active-high): stage=SG, dir=0, timer=0, blink=0. Resulting outputs: grn=1<<0, all other lamp outputs 0. Outputs hold these values for as long as reset is high.
- Red is implied: an approach with no lamp bit set is red. At most one lamp bit across grn/yel/lgrn/lyel is set, except in FLASH.
- Lamp decode (d = dir):
  - SG -> grn[d]
  - SY -> yel[d]
  - LG -> lgrn[d]
  - LY -> lyel[d]
  - FLASH -> yel = {N_DIR{blink}}; grn, lgrn, lyel = 0
- Define mn = (timer >= MIN_GRN-1) and mx = (timer == MAX_GRN-1).
- SG(d):
  - Leaves to SY(d) when mx, or when mn && (!t_str[d] || night).
  - Green therefore lasts MIN_GRN..MAX_GRN cycles. Continuous traffic is cut off at MAX_GRN.
- SY(d): leaves when timer == YEL_CYC-1. Destination priority:
  - FLASH if night=1
  - else LG(d) if LEFT_EN && t_left[d]
  - else SG((d+1) mod N_DIR)
- LG(d): same exit rule as SG, using t_left[d] in place of t_str[d]. Exits to LY(d).
- LY(d): leaves when timer == YEL_CYC-1, to FLASH if night=1, else SG((d+1) mod N_DIR).
- Left-phase skip: t_left[d] is sampled only on the last SY cycle. Demand arriving later waits for the next round.
- dir wrap-around: N_DIR-1 -> 0. For N_DIR not a power of 2, dir never takes the unused encodings.
- FLASH:
  - dir = 0.
  - blink toggles when timer == YEL_CYC-1; timer then restarts at 0.
  - First FLASH cycle has blink=1 (all yellow on).
  - When night=0 in any FLASH cycle, the next state is SG(0) with timer=0.
- Inputs are sampled only at clk rising edges. night changes never truncate a yellow phase.
- Reset mid-phase (any stage) forces the reset state immediately, with no clock edge required. Release resumes at SG(0).

Test Plan:
Configuration for all scenarios: N_DIR=2, LEFT_EN=1, YEL_CYC=3, MIN_GRN=2, MAX_GRN=6.
1. Reset: assert reset for 3 cycles -> grn=2'b01, yel=lgrn=lyel=0, stage=0, dir=0 throughout; outputs are valid before the first clk edge.
2. All sensors 0, night=0 -> repeating 10-cycle cycle: SG0 x2, SY0 x3, SG1 x2, SY1 x3. LG is never entered; grn alternates 01/10.
3. t_str=2'b01 held high -> SG0 lasts exactly 6 cycles (timeout), then SY0 x3, then SG1. Drop t_str[0] at SG0 timer=3 instead -> SG0 lasts 4 cycles.
4. t_left=2'b01 through the last SY0 cycle -> LG0 entered with lgrn=01; t_left[0] cleared at LG timer=0 -> LG0 x2, LY0 x3 (lyel=01), then SG1. t_left[0] first asserted after the last SY0 cycle -> LG0 skipped.
5. night=1 raised at SG1 timer=4 -> SG1 ends that cycle; SY1 x3; FLASH with yel=11 x3, 00 x3, 11 ... Drop night -> next cycle stage=SG, dir=0, grn=01.
6. Assert reset asynchronously mid-LY0 (between clk edges) -> outputs reach reset values before the next edge. On release, the 10-cycle sequence of scenario 2 restarts from SG0 timer=0.
